// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: registered execute-stage ALU behind valid/ready handshakes.
// Define ALU_MULDIV_EN to build in the iterative RV32M multiply/divide unit (CALC state).
module alu_seq_muldiv #(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      select_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_out,
    output logic            busy
);

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t             r_state, w_stateNext;
    logic [XLEN-1:0]    r_result, w_aluResult;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_accept, w_isMulDiv;

    assign in_ready   = (r_state == IDLE) && rst_n;
    assign out_valid  = (r_state == DONE) && rst_n;
    assign w_accept   = in_valid && in_ready;
    assign result_out = r_result;
    assign w_shamt    = operand_b[SHAMT_W-1:0];

    // Single-cycle ops; any unlisted code (and the M codes when they are not built in) is add.
    always_comb begin
        w_aluResult = operand_a + operand_b;
        case (select_op)
            5'h01:   w_aluResult = operand_a - operand_b;
            5'h02:   w_aluResult = operand_a << w_shamt;
            5'h03:   w_aluResult = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            5'h04:   w_aluResult = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            5'h05:   w_aluResult = operand_a ^ operand_b;
            5'h06:   w_aluResult = operand_a >> w_shamt;
            5'h07:   w_aluResult = $signed(operand_a) >>> w_shamt;
            5'h08:   w_aluResult = operand_a | operand_b;
            5'h09:   w_aluResult = operand_a & operand_b;
            default: w_aluResult = operand_a + operand_b;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN + 1);

    logic [CNT_W-1:0]  r_count;
    logic [2*XLEN-1:0] r_acc, w_accStep, w_prod;
    logic [XLEN-1:0]   r_operand, w_aMag, w_bMag, w_quo, w_rem, w_mResult;
    logic [XLEN:0]     w_sum, w_diff;
    logic [2:0]        r_mop;
    logic              r_neg, w_aSigned, w_bSigned, w_aNeg, w_bNeg, w_lastIter;

    assign w_isMulDiv = (select_op[4:3] == 2'b10);
    assign w_lastIter = (r_state == CALC) && (r_count == CNT_W'(1));
    assign busy       = (r_state == CALC) && rst_n;

    always_comb begin
        w_aSigned = select_op[2] ? !select_op[0] : (select_op[1:0] != 2'b11);
        w_bSigned = select_op[2] ? !select_op[0] : !select_op[1];
        w_aNeg    = w_aSigned && operand_a[XLEN-1];
        w_bNeg    = w_bSigned && operand_b[XLEN-1];
        w_aMag    = w_aNeg ? -operand_a : operand_a;
        w_bMag    = w_bNeg ? -operand_b : operand_b;
    end

    // r_acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_operand} : '0);
        w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_operand};
        if (!r_mop[2])
            w_accStep = {w_sum, r_acc[XLEN-1:1]};
        else if (!w_diff[XLEN])
            w_accStep = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        else
            w_accStep = {r_acc[2*XLEN-2:0], 1'b0};
        w_prod = r_neg ? -w_accStep : w_accStep;
        w_quo  = r_neg ? -w_accStep[XLEN-1:0] : w_accStep[XLEN-1:0];
        w_rem  = r_neg ? -w_accStep[2*XLEN-1:XLEN] : w_accStep[2*XLEN-1:XLEN];
        case (r_mop)
            3'd0:             w_mResult = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_mResult = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_mResult = w_quo;
            default:          w_mResult = w_rem;
        endcase
    end

    // Divide by zero skips the quotient negation so it stays all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_mop     <= '0;
            r_neg     <= 1'b0;
        end else if (w_accept && w_isMulDiv) begin
            r_count <= CNT_W'(XLEN);
            r_mop   <= select_op[2:0];
            if (select_op[2]) begin
                r_acc     <= {{XLEN{1'b0}}, w_aMag};
                r_operand <= w_bMag;
                r_neg     <= select_op[1] ? w_aNeg
                                          : ((w_aNeg ^ w_bNeg) && (operand_b != '0));
            end else begin
                r_acc     <= {{XLEN{1'b0}}, w_bMag};
                r_operand <= w_aMag;
                r_neg     <= w_aNeg ^ w_bNeg;
            end
        end else if (r_state == CALC) begin
            r_count <= r_count - CNT_W'(1);
            r_acc   <= w_accStep;
        end
    end
`else
    assign w_isMulDiv = 1'b0;
    assign busy       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
`ifdef ALU_MULDIV_EN
            IDLE:    if (w_accept) w_stateNext = w_isMulDiv ? CALC : DONE;
            CALC:    if (w_lastIter) w_stateNext = DONE;
`else
            IDLE:    if (w_accept) w_stateNext = DONE;
`endif
            DONE:    if (out_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_result <= '0;
        else if (w_accept && !w_isMulDiv)
            r_result <= w_aluResult;
`ifdef ALU_MULDIV_EN
        else if (w_lastIter)
            r_result <= w_mResult;
`endif
    end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, registered successor to the single-cycle ALU.
- Completes the base integer op set, including slt, sltu and sra.
- Masks shift amounts to log2(XLEN) bits.
- Adds iterative multi-cycle multiply/divide (RV32M semantics).
- Sits in the execute stage behind a valid/ready handshake, so the datapath can stall on long ops.

Parameters:
XLEN, 32, operand/result width; must be a power of two, >= 8
SHAMT_W, $clog2(XLEN), shift-amount bits taken from operand_b (derived; do not override)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept; transfer when in_valid && in_ready
operand_a  in  XLEN  first operand (rs1)
operand_b  in  XLEN  second operand (rs2/imm)
select_op  in  5  operation code, see Behaviour
out_valid  out  1  result_out valid
out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
result_out  out  XLEN  registered result
busy  out  1  high in CALC state

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values:
  - state=IDLE, out_valid=0, result_out=0, busy=0, iteration counter=0.
  - in_ready forced 0 while rst_n=0.
- in_ready = (state==IDLE) && rst_n. Operands and select_op are latched on the accept edge only.
- Base op codes (single-cycle; lint/arith on XLEN bits, wrap-around, no flags):
  - 0x00 add, 0x01 sub, 0x02 sll, 0x03 slt (signed, 1/0), 0x04 sltu.
  - 0x05 xor, 0x06 srl, 0x07 sra, 0x08 or, 0x09 and.
  - Shifts use operand_b[SHAMT_W-1:0] only.
- M op codes:
  - 0x10 mul (low XLEN), 0x11 mulh (s×s high), 0x12 mulhsu (s×u high), 0x13 mulhu (u×u high).
  - 0x14 div, 0x15 divu, 0x16 rem, 0x17 remu.
- Any other code: executes as add.
- FSM states IDLE, CALC, DONE:
  - IDLE -> DONE on accept of a base op. Result registered; out_valid=1 next cycle (latency 1).
  - IDLE -> CALC on accept of an M op. Counter loads XLEN; busy=1.
  - CALC: one iteration per cycle. Multiply is radix-2 shift-add on magnitudes with a 2*XLEN accumulator. Divide is restoring, one quotient bit per cycle, on magnitudes.
  - CALC -> DONE when the counter reaches 0 and the sign fix-up is applied. Accept to out_valid = XLEN+1 cycles, fixed for all M ops including special cases.
  - DONE: out_valid=1, result_out stable. DONE -> IDLE when out_ready=1. Holds indefinitely while out_ready=0.
- Back-to-back throughput: one op per 2 cycles (base) or per XLEN+2 cycles (M), with out_ready held high.
- Sign rules:
  - Quotient negative iff operand signs differ (signed div); remainder takes the dividend's sign.
  - Multiply result negated iff the signed-interpreted signs differ.
- Divide by zero: quotient = all ones; remainder = dividend. No trap.
- Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
- Reset mid-operation (CALC or DONE): result abandoned; out_valid never asserted for it; IDLE the cycle after rst_n releases.
- in_valid while not ready is ignored; the requester holds the request.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: M op codes, the CALC state, counter, accumulator and busy logic are compiled in, as above.
- Undefined:
  - CALC and its datapath are removed; busy is tied 0.
  - Codes 0x10–0x17 execute as add with latency 1.
  - Base ops behave identically.

Test Plan:
- add 5+7; sub 3-5 -> result_out 0x0000000C, then 0xFFFFFFFE; each out_valid exactly 1 cycle after accept, out_ready=1.
- sra 0x80000000 with b=0x00000024; sll 0x1 with b=0x21 -> 0xF8000000 (shamt 4), then 0x00000002 (shamt 1).
- slt 0xFFFFFFFF vs 0x1 -> 1; sltu 0xFFFFFFFF vs 0x1 -> 0; code 0x1F with 2,3 -> 5.
- mul 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001; mulh 0x80000000×0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; each out_valid 33 cycles after accept, busy high for 32.
- div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; div 7/0 -> 0xFFFFFFFF; rem 7/0 -> 7; div 0x80000000/-1 -> 0x80000000; rem of same -> 0.
- Backpressure and reset:
  - out_ready=0 for 5 cycles in DONE -> result_out held, in_ready=0, new in_valid ignored.
  - rst_n low for 1 cycle mid-CALC -> no out_valid for the aborted op; in_ready=1 the first cycle after release.
